// File: rtl/smp_bus_pkg.sv
// Shared types and defaults for the SMP coherence bus and main-memory controller.
package smp_bus_pkg;

   localparam int DEF_ADDR_W = 11;
   localparam int DEF_DATA_W = 16;

   // Wide enough for MEM_LAT up to 15
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      OP_RD   = 2'd0,
      OP_RDX  = 2'd1,
      OP_WB   = 2'd2,
      OP_RSVD = 2'd3
   } bus_op_t;

   typedef logic cpu_id_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNOOP = 2'd1,
      MEM   = 2'd2,
      RESP  = 2'd3
   } memctl_state_t;

   // Read-type ops open a snoop window and return data
   function automatic logic op_is_read(input bus_op_t op);
      return (op == OP_RD) || (op == OP_RDX);
   endfunction

endpackage

// File: rtl/shared_mem_ctrl_if.sv
// Bus-side request/snoop/response signals between the coherence bus and the memory controller.
interface shared_mem_ctrl_if #(
   parameter int ADDR_W = smp_bus_pkg::DEF_ADDR_W,
   parameter int DATA_W = smp_bus_pkg::DEF_DATA_W
);
   import smp_bus_pkg::*;

   logic              req_valid;
   logic              req_ready;
   bus_op_t           req_op;
   cpu_id_t           req_src;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              snoop_hit;
   logic [DATA_W-1:0] snoop_data;
   logic              rsp_valid;
   logic              rsp_ready;
   cpu_id_t           rsp_dst;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              busy;

   // Bus side: issues requests, supplies snoop results, consumes responses
   modport master (
      output req_valid, req_op, req_src, req_addr, req_wdata,
      output snoop_hit, snoop_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_dst, rsp_data, rsp_err, busy
   );

   // Controller side
   modport slave (
      input  req_valid, req_op, req_src, req_addr, req_wdata,
      input  snoop_hit, snoop_data, rsp_ready,
      output req_ready, rsp_valid, rsp_dst, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/smp_mem_array.sv
// Single-port synchronous RAM with one write enable and a registered read port.
module smp_mem_array #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write when enabled; read is registered every cycle (read-before-write)
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/shared_mem_ctrl.sv
// Main-memory controller behind the snooping bus: one transaction at a time, a one-cycle
// snoop window for cache-to-cache intervention, otherwise a fixed-latency array access.
module shared_mem_ctrl #(
   parameter int ADDR_W  = smp_bus_pkg::DEF_ADDR_W,
   parameter int DATA_W  = smp_bus_pkg::DEF_DATA_W,
   parameter int MEM_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   shared_mem_ctrl_if.slave bus
);
   import smp_bus_pkg::*;

   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

   memctl_state_t     state;
   logic [CNT_W-1:0]  cnt;
   logic              req_ready_q;
   logic              busy_q;
   logic              rsp_valid_q;
   cpu_id_t           rsp_dst_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;

   bus_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   assign accept = bus.req_valid && req_ready_q;

   // Request payload capture; pure data, so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= bus.req_op;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   // Array write: RD intervention shares the dirty line back; WB commits on its last MEM cycle.
   // Both sources come from reset state, so a reset before the commit cycle writes nothing.
   always_comb begin
      ram_we    = 1'b0;
      ram_wdata = wdata_q;
      if (state == SNOOP && bus.snoop_hit && op_q == OP_RD) begin
         ram_we    = 1'b1;
         ram_wdata = bus.snoop_data;
      end else if (state == MEM && cnt == '0 && op_q == OP_WB) begin
         ram_we    = 1'b1;
      end
   end

   smp_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr_q),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Controller FSM with latency counter and registered response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dst_q   <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  rsp_dst_q   <= bus.req_src;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b0;
                  if (op_is_read(bus.req_op)) begin
                     state <= SNOOP;
                  end else if (bus.req_op == OP_WB) begin
                     state <= MEM;
                     cnt   <= LAT_INIT;
                  end else begin
                     state       <= RESP;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end
            SNOOP: begin
               if (bus.snoop_hit) begin
                  state       <= RESP;
                  rsp_data_q  <= bus.snoop_data;
                  rsp_valid_q <= 1'b1;
               end else begin
                  state <= MEM;
                  cnt   <= LAT_INIT;
               end
            end
            MEM: begin
               if (cnt == '0) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  if (op_is_read(op_q)) rsp_data_q <= ram_rdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dst   = rsp_dst_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Scoreboard bench for shared_mem_ctrl: expected responses queued at issue, checked on rsp_valid.
module tb_shared_mem_ctrl;
   import smp_bus_pkg::*;

   localparam int ADDR_W  = 11;
   localparam int DATA_W  = 16;
   localparam int MEM_LAT = 4;

   typedef struct {
      logic              dst;
      logic [DATA_W-1:0] data;
      logic              err;
      int                lat;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   shared_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   shared_mem_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // snoop_mode: 0 none, 1 hit in SNOOP window, 2 pulse during the first MEM cycles
   task automatic run_txn(input bus_op_t op, input logic src, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int snoop_mode,
                          input logic [DATA_W-1:0] sdata, input logic [DATA_W-1:0] exp_data,
                          input logic exp_err, input int exp_lat, input int hold);
      exp_t e;
      exp_t g;
      int   lat;
      int   waits;
      bit   done;
      e.dst = src; e.data = exp_data; e.err = exp_err; e.lat = exp_lat;
      @(negedge clk);
      waits = 0;
      while (!bus.req_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!bus.req_ready) begin
         check_val("req_ready_wait", 32'(bus.req_ready), 32'd1);
         return;
      end
      sb.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_src   = src;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat  = 1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         bus.snoop_hit  = (snoop_mode == 1 && lat == 1) || (snoop_mode == 2 && (lat == 2 || lat == 3));
         bus.snoop_data = bus.snoop_hit ? sdata : 16'h0;
         if (bus.rsp_valid) done = 1'b1;
         else begin
            @(posedge clk);
            @(negedge clk);
            lat++;
         end
      end
      bus.snoop_hit  = 1'b0;
      bus.snoop_data = 16'h0;
      check_val("rsp_timeout", 32'(done), 32'd1);
      g = sb.pop_front();
      if (!done) return;
      check_val("rsp_data", 32'(bus.rsp_data), 32'(g.data));
      check_val("rsp_dst", 32'(bus.rsp_dst), 32'(g.dst));
      check_val("rsp_err", 32'(bus.rsp_err), 32'(g.err));
      check_val("latency", 32'(lat), 32'(g.lat));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("hold_data", 32'(bus.rsp_data), 32'(g.data));
         check_val("hold_err", 32'(bus.rsp_err), 32'(g.err));
         check_val("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_val("post_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("post_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = OP_RD;
      bus.req_src    = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.snoop_hit  = 1'b0;
      bus.snoop_data = '0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("rst_rsp_dst", 32'(bus.rsp_dst), 32'd0);
      check_val("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check_val("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);

      // Reset in the middle of a WB must not commit it
      run_txn(OP_WB, 1'b0, 11'h010, 16'h5555, 0, 16'h0, 16'h0000, 1'b0, MEM_LAT + 1, 0);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_WB;
      bus.req_src   = 1'b0;
      bus.req_addr  = 11'h010;
      bus.req_wdata = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_val("abort_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check_val("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("abort_busy_low", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("abort_idle_valid", 32'(bus.rsp_valid), 32'd0);
      end
      run_txn(OP_RD, 1'b1, 11'h010, 16'h0, 0, 16'h0, 16'h5555, 1'b0, MEM_LAT + 2, 0);

      // WB then RD miss of the same word
      run_txn(OP_WB, 1'b0, 11'h123, 16'hA5A5, 0, 16'h0, 16'h0000, 1'b0, MEM_LAT + 1, 0);
      run_txn(OP_RD, 1'b1, 11'h123, 16'h0, 0, 16'h0, 16'hA5A5, 1'b0, MEM_LAT + 2, 0);

      // RD with intervention updates memory
      run_txn(OP_RD, 1'b0, 11'h040, 16'h0, 1, 16'h1234, 16'h1234, 1'b0, 2, 0);
      run_txn(OP_RD, 1'b1, 11'h040, 16'h0, 0, 16'h0, 16'h1234, 1'b0, MEM_LAT + 2, 0);

      // RDX with intervention leaves memory alone
      run_txn(OP_WB, 1'b1, 11'h041, 16'h0001, 0, 16'h0, 16'h0000, 1'b0, MEM_LAT + 1, 0);
      run_txn(OP_RDX, 1'b0, 11'h041, 16'h0, 1, 16'h7777, 16'h7777, 1'b0, 2, 0);
      run_txn(OP_RD, 1'b0, 11'h041, 16'h0, 0, 16'h0, 16'h0001, 1'b0, MEM_LAT + 2, 0);

      // Reserved opcode, response held off for 5 cycles
      run_txn(OP_RSVD, 1'b1, 11'h055, 16'hFFFF, 0, 16'h0, 16'h0000, 1'b1, 1, 5);

      // snoop_hit during MEM is ignored
      run_txn(OP_WB, 1'b0, 11'h200, 16'h3C3C, 0, 16'h0, 16'h0000, 1'b0, MEM_LAT + 1, 0);
      run_txn(OP_RD, 1'b1, 11'h200, 16'h0, 2, 16'hDEAD, 16'h3C3C, 1'b0, MEM_LAT + 2, 0);

      // Highest address, no wrap
      run_txn(OP_WB, 1'b1, 11'h7FF, 16'h8001, 0, 16'h0, 16'h0000, 1'b0, MEM_LAT + 1, 0);
      run_txn(OP_RDX, 1'b0, 11'h7FF, 16'h0, 0, 16'h0, 16'h8001, 1'b0, MEM_LAT + 2, 0);

      check_val("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
